// File: rtl/mem_access_ctrl_if.sv
// Data-memory bus between the MEM-stage access controller (master)
// and the memory (slave).
interface mem_access_ctrl_if;
  logic        dmem_read;
  logic        dmem_write;
  logic [15:0] dmem_address;
  logic [1:0]  dmem_wmask;
  logic [15:0] dmem_wdata;
  logic        dmem_resp;
  logic [15:0] dmem_rdata;

  modport master (
    output dmem_read,
    output dmem_write,
    output dmem_address,
    output dmem_wmask,
    output dmem_wdata,
    input  dmem_resp,
    input  dmem_rdata
  );

  modport slave (
    input  dmem_read,
    input  dmem_write,
    input  dmem_address,
    input  dmem_wmask,
    input  dmem_wdata,
    output dmem_resp,
    output dmem_rdata
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// MEM-stage access controller: stalls the pipeline while a load/store
// (optionally through a memory pointer) completes on the data-memory bus.
module mem_access_ctrl (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mem_valid,
  input  logic              read,
  input  logic              write,
  input  logic              indirect,
  input  logic [1:0]        mem_byte_sig,
  input  logic [15:0]       address,
  input  logic [15:0]       wdata,
  mem_access_ctrl_if.master mem,
  output logic              stall,
  output logic              done,
  output logic [15:0]       rdata,
  output logic [15:0]       stall_count
);

  typedef enum logic [1:0] {IDLE, IND_FETCH, ACCESS, DONE} state_t;

  state_t      state;
  logic        rd_q;
  logic        wr_q;
  logic        ind_q;
  logic        byte_q;
  logic [15:0] addr_q;
  logic [15:0] wdata_q;
  logic [15:0] pointer;
  logic        capture;
  logic [15:0] target;

  always_comb begin
    capture = (state == IDLE) && mem_valid && (read || write);
    stall   = capture || (state == IND_FETCH) || (state == ACCESS);
  end

  // The pointer fetch always uses the captured address; only the second
  // step of an indirect access follows the fetched pointer.
  always_comb begin
    target           = (state == ACCESS && ind_q) ? pointer : addr_q;
    mem.dmem_address = {target[15:1], 1'b0};
    if (!mem.dmem_write)
      mem.dmem_wmask = 2'b00;
    else if (!byte_q)
      mem.dmem_wmask = 2'b11;
    else
      mem.dmem_wmask = target[0] ? 2'b10 : 2'b01;
    mem.dmem_wdata = byte_q ? {wdata_q[7:0], wdata_q[7:0]} : wdata_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= IDLE;
      rd_q           <= 1'b0;
      wr_q           <= 1'b0;
      ind_q          <= 1'b0;
      byte_q         <= 1'b0;
      addr_q         <= 16'h0000;
      wdata_q        <= 16'h0000;
      pointer        <= 16'h0000;
      rdata          <= 16'h0000;
      stall_count    <= 16'h0000;
      done           <= 1'b0;
      mem.dmem_read  <= 1'b0;
      mem.dmem_write <= 1'b0;
    end else begin
      if (stall && stall_count != 16'hFFFF)
        stall_count <= stall_count + 16'd1;

      case (state)
        IDLE: begin
          if (capture) begin
            // Read wins over write; indirect accesses are always word-sized.
            rd_q           <= read;
            wr_q           <= write && !read;
            ind_q          <= indirect;
            byte_q         <= (mem_byte_sig == 2'b01) && !indirect;
            addr_q         <= address;
            wdata_q        <= wdata;
            mem.dmem_read  <= read || indirect;
            mem.dmem_write <= write && !read && !indirect;
            state          <= indirect ? IND_FETCH : ACCESS;
          end
        end

        IND_FETCH: begin
          if (mem.dmem_resp) begin
            pointer        <= mem.dmem_rdata;
            mem.dmem_read  <= rd_q;
            mem.dmem_write <= wr_q;
            state          <= ACCESS;
          end
        end

        ACCESS: begin
          if (mem.dmem_resp) begin
            if (rd_q) begin
              if (byte_q)
                rdata <= {8'h00, target[0] ? mem.dmem_rdata[15:8] : mem.dmem_rdata[7:0]};
              else
                rdata <= mem.dmem_rdata;
            end
            mem.dmem_read  <= 1'b0;
            mem.dmem_write <= 1'b0;
            done           <= 1'b1;
            state          <= DONE;
          end
        end

        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: a latency-programmable memory
// responder plus a transaction-level reference model.
module tb_mem_access_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_valid;
  logic        read;
  logic        write;
  logic        indirect;
  logic [1:0]  mem_byte_sig;
  logic [15:0] address;
  logic [15:0] wdata;
  logic        stall;
  logic        done;
  logic [15:0] rdata;
  logic [15:0] stall_count;

  mem_access_ctrl_if mif ();

  mem_access_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .mem_valid    (mem_valid),
    .read         (read),
    .write        (write),
    .indirect     (indirect),
    .mem_byte_sig (mem_byte_sig),
    .address      (address),
    .wdata        (wdata),
    .mem          (mif),
    .stall        (stall),
    .done         (done),
    .rdata        (rdata),
    .stall_count  (stall_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        wr;
    logic [15:0] addr;
    logic [1:0]  mask;
    logic [15:0] wd;
  } rec_t;

  int          checks   = 0;
  int          failures = 0;
  logic [15:0] mem [0:65535];
  int          lat_a    = 1;
  int          lat_b    = 1;
  int          resp_cnt = 0;
  int          req_idx  = 0;
  rec_t        rec_q [$];
  logic [15:0] model_rdata;
  logic [15:0] model_sc;
  int          s_stall;
  int          s_done;
  int          s_strobe;
  int          s_badmask;

  // One clock: the memory answers each request after lat_a (first) or
  // lat_b (second) cycles and logs every completed bus transfer.
  task automatic tick();
    int   need;
    rec_t r;
    @(negedge clk);
    if (rst_n !== 1'b1 || (mif.dmem_read !== 1'b1 && mif.dmem_write !== 1'b1)) begin
      resp_cnt      = 0;
      req_idx       = 0;
      mif.dmem_resp = 1'b0;
    end else begin
      if (mif.dmem_resp === 1'b1) begin
        resp_cnt = 0;
        req_idx++;
      end
      resp_cnt++;
      need = (req_idx == 0) ? lat_a : lat_b;
      if (resp_cnt >= need) begin
        mif.dmem_resp  = 1'b1;
        mif.dmem_rdata = mem[mif.dmem_address];
        r.wr   = mif.dmem_write;
        r.addr = mif.dmem_address;
        r.mask = mif.dmem_wmask;
        r.wd   = (mif.dmem_write === 1'b1) ? mif.dmem_wdata : 16'h0000;
        rec_q.push_back(r);
      end else begin
        mif.dmem_resp  = 1'b0;
        mif.dmem_rdata = 16'($urandom);
      end
    end
    #1;
  endtask

  task automatic sample();
    if (stall === 1'b1) s_stall++;
    if (done === 1'b1) s_done++;
    if (mif.dmem_read === 1'b1 || mif.dmem_write === 1'b1) s_strobe++;
    if (mif.dmem_write !== 1'b1 && mif.dmem_wmask !== 2'b00) s_badmask++;
  endtask

  task automatic clear_inputs();
    mem_valid    = 1'b0;
    read         = 1'b0;
    write        = 1'b0;
    indirect     = 1'b0;
    mem_byte_sig = 2'b00;
    address      = 16'($urandom);
    wdata        = 16'($urandom);
  endtask

  // Issues one MEM-stage instruction, holds it while stalled, and checks
  // timing, bus transfers and results against the transaction model.
  task automatic run_op(input string name, input logic rd, input logic wr,
                        input logic ind, input logic [1:0] bsig,
                        input logic [15:0] addr, input logic [15:0] wd,
                        input int la, input int lb, input int budget);
    logic        active;
    logic        eff_wr;
    logic        byte_acc;
    logic [15:0] target;
    logic [15:0] word;
    logic [15:0] exp_rdata;
    logic [1:0]  exp_mask;
    logic [15:0] exp_wd;
    rec_t        exp_q [$];
    rec_t        e;
    int          exp_stall;
    int          exp_strobe;
    int          sum;
    bit          finished;

    active   = rd | wr;
    eff_wr   = wr & ~rd;
    byte_acc = (bsig == 2'b01) && !ind;
    target   = ind ? mem[{addr[15:1], 1'b0}] : addr;
    word     = mem[{target[15:1], 1'b0}];
    if (!eff_wr) exp_mask = 2'b00;
    else if (!byte_acc) exp_mask = 2'b11;
    else exp_mask = target[0] ? 2'b10 : 2'b01;
    exp_wd = !eff_wr ? 16'h0000 : (byte_acc ? {wd[7:0], wd[7:0]} : wd);
    if (active && ind) begin
      e = '{wr: 1'b0, addr: {addr[15:1], 1'b0}, mask: 2'b00, wd: 16'h0000};
      exp_q.push_back(e);
    end
    if (active) begin
      e = '{wr: eff_wr, addr: {target[15:1], 1'b0}, mask: exp_mask, wd: exp_wd};
      exp_q.push_back(e);
    end
    if (active && rd)
      exp_rdata = byte_acc ? {8'h00, (target[0] ? word[15:8] : word[7:0])} : word;
    else
      exp_rdata = model_rdata;
    exp_stall  = active ? (1 + la + (ind ? lb : 0)) : 0;
    exp_strobe = active ? (la + (ind ? lb : 0)) : 0;
    sum        = int'(model_sc) + exp_stall;
    model_sc   = (sum > 65535) ? 16'hFFFF : 16'(sum);
    model_rdata = exp_rdata;

    rec_q.delete();
    lat_a = la;
    lat_b = lb;
    s_stall = 0; s_done = 0; s_strobe = 0; s_badmask = 0;
    mem_valid    = 1'b1;
    read         = rd;
    write        = wr;
    indirect     = ind;
    mem_byte_sig = bsig;
    address      = addr;
    wdata        = wd;
    #1;
    sample();
    finished = 1'b0;
    for (int c = 0; c < budget; c++) begin
      if (done === 1'b1 || (c == 0 && stall !== 1'b1)) begin
        clear_inputs();
        tick();
        sample();
        finished = 1'b1;
        break;
      end
      tick();
      sample();
    end

    checks++;
    if (!finished) begin
      failures++;
      $display("[TB] FAIL %s timeout: no completion within %0d cycles", name, budget);
      clear_inputs();
      return;
    end
    checks++;
    if (s_stall !== exp_stall) begin
      failures++;
      $display("[TB] FAIL %s stall_cycles: got %0d expected %0d", name, s_stall, exp_stall);
    end
    checks++;
    if (s_done !== (active ? 1 : 0)) begin
      failures++;
      $display("[TB] FAIL %s done_pulses: got %0d expected %0d", name, s_done, active ? 1 : 0);
    end
    checks++;
    if (s_strobe !== exp_strobe) begin
      failures++;
      $display("[TB] FAIL %s strobe_cycles: got %0d expected %0d", name, s_strobe, exp_strobe);
    end
    checks++;
    if (s_badmask !== 0) begin
      failures++;
      $display("[TB] FAIL %s wmask_without_write: got %0d cycles expected 0", name, s_badmask);
    end
    checks++;
    if (rec_q.size() !== exp_q.size()) begin
      failures++;
      $display("[TB] FAIL %s transfer_count: got %0d expected %0d", name, rec_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < rec_q.size(); i++) begin
      checks++;
      if (rec_q[i] !== exp_q[i]) begin
        failures++;
        $display("[TB] FAIL %s transfer%0d: got wr=%b addr=%h mask=%b wd=%h expected wr=%b addr=%h mask=%b wd=%h",
                 name, i, rec_q[i].wr, rec_q[i].addr, rec_q[i].mask, rec_q[i].wd,
                 exp_q[i].wr, exp_q[i].addr, exp_q[i].mask, exp_q[i].wd);
      end
    end
    checks++;
    if (rdata !== exp_rdata) begin
      failures++;
      $display("[TB] FAIL %s rdata: got %h expected %h", name, rdata, exp_rdata);
    end
    checks++;
    if (stall_count !== model_sc) begin
      failures++;
      $display("[TB] FAIL %s stall_count: got %h expected %h", name, stall_count, model_sc);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    clear_inputs();
    repeat (3) tick();
    checks++;
    if ({stall, done, mif.dmem_read, mif.dmem_write, mif.dmem_wmask} !== 6'b0) begin
      failures++;
      $display("[TB] FAIL reset_strobes: got stall=%b done=%b rd=%b wr=%b mask=%b expected all 0",
               stall, done, mif.dmem_read, mif.dmem_write, mif.dmem_wmask);
    end
    checks++;
    if (rdata !== 16'h0000 || stall_count !== 16'h0000) begin
      failures++;
      $display("[TB] FAIL reset_regs: got rdata=%h stall_count=%h expected 0000/0000", rdata, stall_count);
    end
    rst_n = 1'b1;
    tick();
    checks++;
    if (stall !== 1'b0 || stall_count !== 16'h0000) begin
      failures++;
      $display("[TB] FAIL reset_release: got stall=%b stall_count=%h expected 0/0000", stall, stall_count);
    end
    model_rdata = 16'h0000;
    model_sc    = 16'h0000;
  endtask

  task automatic test_ldr();
    mem[16'h1234] = 16'hBEEF;
    run_op("LDR", 1'b1, 1'b0, 1'b0, 2'b00, 16'h1234, 16'h0000, 3, 1, 40);
    checks++;
    if (rdata !== 16'hBEEF) begin
      failures++;
      $display("[TB] FAIL LDR_literal: got %h expected BEEF", rdata);
    end
  endtask

  task automatic test_ldb();
    mem[16'h2000] = 16'hA55A;
    run_op("LDB", 1'b1, 1'b0, 1'b0, 2'b01, 16'h2001, 16'h0000, 2, 1, 40);
    checks++;
    if (rdata !== 16'h00A5) begin
      failures++;
      $display("[TB] FAIL LDB_literal: got %h expected 00A5", rdata);
    end
  endtask

  task automatic test_stb();
    mem[16'h3002] = 16'h0000;
    run_op("STB", 1'b0, 1'b1, 1'b0, 2'b01, 16'h3003, 16'h12CD, 2, 1, 40);
    checks++;
    if (rdata !== 16'h00A5) begin
      failures++;
      $display("[TB] FAIL STB_rdata_held: got %h expected 00A5", rdata);
    end
  endtask

  task automatic test_ldi();
    mem[16'h4000] = 16'h5002;
    mem[16'h5002] = 16'h0077;
    run_op("LDI", 1'b1, 1'b0, 1'b1, 2'b00, 16'h4000, 16'h0000, 1, 1, 40);
    checks++;
    if (rdata !== 16'h0077) begin
      failures++;
      $display("[TB] FAIL LDI_literal: got %h expected 0077", rdata);
    end
  endtask

  task automatic test_noop();
    run_op("ADD", 1'b0, 1'b0, 1'b0, 2'b00, 16'h1111, 16'h2222, 1, 1, 10);
  endtask

  task automatic test_reset_mid_access();
    lat_a = 100;
    rec_q.delete();
    mem_valid = 1'b1; read = 1'b0; write = 1'b1; indirect = 1'b0;
    mem_byte_sig = 2'b00; address = 16'h6006; wdata = 16'h5AA5;
    repeat (3) tick();
    checks++;
    if (mif.dmem_write !== 1'b1) begin
      failures++;
      $display("[TB] FAIL STR_in_access: got dmem_write=%b expected 1", mif.dmem_write);
    end
    rst_n = 1'b0;
    clear_inputs();
    tick();
    checks++;
    if ({mif.dmem_read, mif.dmem_write, mif.dmem_wmask, stall, done} !== 6'b0 ||
        stall_count !== 16'h0000) begin
      failures++;
      $display("[TB] FAIL STR_reset: got rd=%b wr=%b mask=%b stall=%b done=%b sc=%h expected all 0",
               mif.dmem_read, mif.dmem_write, mif.dmem_wmask, stall, done, stall_count);
    end
    rst_n = 1'b1;
    mif.dmem_resp  = 1'b1;
    mif.dmem_rdata = 16'hDEAD;
    tick();
    tick();
    checks++;
    if ({mif.dmem_read, mif.dmem_write, stall, done} !== 4'b0 || rdata !== 16'h0000) begin
      failures++;
      $display("[TB] FAIL late_resp: got rd=%b wr=%b stall=%b done=%b rdata=%h expected 0/0/0/0/0000",
               mif.dmem_read, mif.dmem_write, stall, done, rdata);
    end
    model_rdata = 16'h0000;
    model_sc    = 16'h0000;
    mem[16'h6100] = 16'h4321;
    run_op("LDR_after_reset", 1'b1, 1'b0, 1'b0, 2'b00, 16'h6100, 16'h0000, 2, 1, 40);
  endtask

  task automatic test_priority();
    mem[16'h7000] = 16'h1357;
    run_op("RW_both", 1'b1, 1'b1, 1'b0, 2'b00, 16'h7000, 16'hFFFF, 2, 1, 40);
    mem[16'h8000] = 16'h9003;
    mem[16'h9002] = 16'hABCD;
    run_op("LDI_byte_sig", 1'b1, 1'b0, 1'b1, 2'b01, 16'h8001, 16'h0000, 2, 3, 40);
    mem[16'hA000] = 16'hB001;
    run_op("STI_word", 1'b0, 1'b1, 1'b1, 2'b01, 16'hA000, 16'h6789, 1, 2, 40);
    run_op("STB_low", 1'b0, 1'b1, 1'b0, 2'b01, 16'hC004, 16'h00EE, 1, 1, 40);
  endtask

  task automatic test_random();
    logic        rd;
    logic        wr;
    logic        ind;
    logic [1:0]  bsig;
    logic [15:0] addr;
    logic [15:0] ptr;
    for (int i = 0; i < 40; i++) begin
      rd   = 1'($urandom_range(0, 1));
      wr   = 1'($urandom_range(0, 1));
      ind  = 1'($urandom_range(0, 1));
      bsig = 2'($urandom_range(0, 3));
      addr = 16'($urandom);
      ptr  = 16'($urandom);
      mem[{addr[15:1], 1'b0}] = ptr;
      if (ind) mem[{ptr[15:1], 1'b0}] = 16'($urandom);
      run_op("RAND", rd, wr, ind, bsig, addr, 16'($urandom),
             $urandom_range(1, 4), $urandom_range(1, 4), 40);
    end
  endtask

  task automatic test_saturation();
    mem[16'h0A0A] = 16'h0F0F;
    run_op("SAT_LDR", 1'b1, 1'b0, 1'b0, 2'b00, 16'h0A0A, 16'h0000, 65540, 1, 70000);
    checks++;
    if (stall_count !== 16'hFFFF) begin
      failures++;
      $display("[TB] FAIL sat_literal: got %h expected FFFF", stall_count);
    end
    run_op("SAT_STR", 1'b0, 1'b1, 1'b0, 2'b00, 16'h0B0B, 16'h1234, 2, 1, 40);
    checks++;
    if (stall_count !== 16'hFFFF) begin
      failures++;
      $display("[TB] FAIL sat_hold: got %h expected FFFF", stall_count);
    end
  endtask

  initial begin
    rst_n          = 1'b0;
    mif.dmem_resp  = 1'b0;
    mif.dmem_rdata = 16'h0000;
    model_rdata    = 16'h0000;
    model_sc       = 16'h0000;
    clear_inputs();
    $display("[TB] starting mem_access_ctrl bench");
    test_reset();
    test_ldr();
    test_ldb();
    test_stb();
    test_ldi();
    test_noop();
    test_reset_mid_access();
    test_priority();
    test_random();
    test_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 SHALL have a single clock and a synchronous, active-low reset. Ports (name, direction, width, meaning):
- clk  in  1  rising-edge clock for all state.
- rst_n  in  1  synchronous active-low reset.
REQ-002 SHALL provide these pipeline-side inputs:
- mem_valid  in  1  valid instruction in MEM stage; inputs below held stable while stall=1.
- read, write, indirect  in  1 each  MEM controls from decode.
- mem_byte_sig  in  2  2'b01 = byte access; any other value = word access.
- address  in  16  ALU result (effective address).
- wdata  in  16  store source register.
REQ-003 SHALL provide these memory-side signals:
- dmem_resp  in  1  memory access complete.
- dmem_rdata  in  16  memory read data.
- dmem_read, dmem_write  out  1 each  memory request strobes.
- dmem_address  out  16  word-aligned address.
- dmem_wmask  out  2  byte-lane write enables.
- dmem_wdata  out  16  write data.
REQ-004 SHALL provide these pipeline-side outputs:
- stall  out  1  freeze pipeline.
- done  out  1  one-cycle completion pulse.
- rdata  out  16  load result.
- stall_count  out  16  saturating count of stalled cycles.

Function
REQ-005 SHALL implement states IDLE, IND_FETCH, ACCESS, DONE.
REQ-006 In IDLE, with mem_valid & (read|write), it SHALL capture read, write, indirect, byte flag, address and wdata, then enter IND_FETCH if indirect=1, else ACCESS.
REQ-007 SHALL drive stall=1 combinationally in the capture cycle and throughout IND_FETCH and ACCESS; stall=0 in DONE and for non-memory or invalid cycles.
REQ-008 SHALL treat mem_valid=1 with read=write=0 as a no-op: no state change, stall=0, done=0.
REQ-009 SHALL give read priority when read=write=1: the access is performed as a read and the write is ignored.
REQ-010 IND_FETCH SHALL assert dmem_read at {addr[15:1],0}; on dmem_resp it SHALL latch dmem_rdata as the pointer and enter ACCESS.
REQ-011 ACCESS SHALL use the pointer as the target for indirect accesses and the captured address otherwise.
REQ-012 ACCESS SHALL assert dmem_read (read) or dmem_write (write), hold it until the cycle dmem_resp=1, then enter DONE.
REQ-013 dmem_address SHALL always equal {target[15:1],1'b0}; indirect accesses SHALL always be word accesses at both steps.
REQ-014 For a word write: dmem_wmask=2'b11 and dmem_wdata=wdata.
REQ-015 For a byte write: dmem_wmask=2'b10 if target[0]=1, else 2'b01; dmem_wdata={wdata[7:0],wdata[7:0]}.
REQ-016 dmem_wmask SHALL be 2'b00 whenever dmem_write=0.
REQ-017 On read completion, rdata SHALL load dmem_rdata for word accesses; for byte accesses it SHALL load {8'h00, target[0] ? dmem_rdata[15:8] : dmem_rdata[7:0]}.
REQ-018 rdata SHALL hold its value until the next read completion; writes SHALL NOT change rdata.
REQ-019 DONE SHALL last exactly one cycle with done=1 and stall=0, then return to IDLE without resampling mem_valid.
REQ-020 Latency SHALL be 1 + k cycles from capture to DONE for direct accesses, where k is the number of cycles up to and including dmem_resp.
REQ-021 For indirect accesses the latency SHALL be 1 + k1 + k2 cycles, where k1 and k2 are the response times of the two accesses.
REQ-022 SHALL ignore dmem_resp in IDLE and DONE, and SHALL ignore pipeline inputs outside the capture cycle.
REQ-023 stall_count SHALL increment on every cycle with stall=1 and saturate at 16'hFFFF.

Reset
REQ-024 While rst_n=0 at a clock edge: state=IDLE; rdata, pointer, captured registers and stall_count = 0.
REQ-025 After the reset edge, dmem_read, dmem_write and done SHALL be 0 and dmem_wmask SHALL be 2'b00.
REQ-026 Reset asserted mid-access SHALL abandon the access; a late dmem_resp SHALL be ignored.

Verification
REQ-027 The bench SHALL cover:
- LDR, address 16'h1234, resp after 3 cycles, dmem_rdata 16'hBEEF -> dmem_address 16'h1234, stall 4 cycles, rdata 16'hBEEF, done pulses once.
- LDB, address 16'h2001, dmem_rdata 16'hA55A -> dmem_address 16'h2000, rdata 16'h00A5.
- STB, address 16'h3003, wdata 16'h12CD -> dmem_wmask 2'b10, dmem_wdata 16'hCDCD, rdata unchanged.
- LDI, address 16'h4000, mem[16'h4000]=16'h5002, mem[16'h5002]=16'h0077, resp=1 immediately -> reads at 16'h4000 then 16'h5002, rdata 16'h0077, stall 3 cycles.
- ADD (read=write=0) -> stall 0, no dmem strobe; then STR with rst_n=0 during ACCESS -> strobes 0 next cycle, state IDLE, stall_count 0.
